// File: rtl/banco_registros_param.sv
// rtl/banco_registros_param.sv - parametrised register file: 1 write port, 2 registered read ports,
// read-during-write bypass, optional hardwired zero register and sequential bulk-clear engine.
module banco_registros_param #(
  parameter int WIDTH    = 8,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [WIDTH-1:0]  w_data,
  input  logic              en_addr,
  input  logic [ADDR_W-1:0] r_addr_a,
  input  logic [ADDR_W-1:0] r_addr_b,
  output logic [WIDTH-1:0]  r_data_a,
  output logic [WIDTH-1:0]  r_data_b,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_done
);

  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_ptr;
  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [WIDTH-1:0]  r_rd_a;
  logic [WIDTH-1:0]  r_rd_b;
  logic              r_busy;
  logic              r_done;
  logic              w_busy_nxt;
  logic              w_done_nxt;
  logic              w_we;
  logic              w_clr;
  logic [DEPTH-1:0]  w_dec;
  logic [WIDTH-1:0]  w_rd_a;
  logic [WIDTH-1:0]  w_rd_b;

  assign w_we  = en_addr & ~r_busy;
  assign w_clr = (r_state == S_CLEAR);

  always_comb begin
    w_dec = '0;
    if (w_we) w_dec[w_addr] = 1'b1;
    if (ZERO_REG != 0) w_dec[0] = 1'b0;
  end

  // The sweep owns the array while busy; w_dec is already gated off then.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ZERO_REG != 0 && i == 0)            r_mem[i] <= '0;
        else if (w_clr && r_ptr == ADDR_W'(i))  r_mem[i] <= '0;
        else if (w_dec[i])                      r_mem[i] <= w_data;
      end
    end
  end

  always_comb begin
    w_rd_a = r_mem[r_addr_a];
    w_rd_b = r_mem[r_addr_b];
    if (BYPASS != 0 && w_we && w_addr == r_addr_a) w_rd_a = w_data;
    if (BYPASS != 0 && w_we && w_addr == r_addr_b) w_rd_b = w_data;
    if (ZERO_REG != 0 && r_addr_a == '0) w_rd_a = '0;
    if (ZERO_REG != 0 && r_addr_b == '0) w_rd_b = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_a <= '0;
      r_rd_b <= '0;
    end else begin
      r_rd_a <= w_rd_a;
      r_rd_b <= w_rd_b;
    end
  end

  assign r_data_a = r_rd_a;
  assign r_data_b = r_rd_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      if (w_clr) r_ptr <= r_ptr + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (clr_req) w_state_nxt = S_CLEAR;
      S_CLEAR: if (r_ptr == ADDR_W'(DEPTH - 1)) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Flags are decoded from the next state and registered so they never glitch.
  always_comb begin
    w_busy_nxt = (w_state_nxt == S_CLEAR);
    w_done_nxt = (w_state_nxt == S_DONE);
  end

  assign busy     = r_busy;
  assign clr_done = r_done;

endmodule

// File: tb/tb_banco_registros_param.sv
// tb/tb_banco_registros_param.sv - directed bench for banco_registros_param with default,
// no-bypass and zero-register instances driven from a shared stimulus.
module tb_banco_registros_param;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] w_addr;
  logic [7:0] w_data;
  logic       en_addr;
  logic [2:0] r_addr_a;
  logic [2:0] r_addr_b;
  logic       clr_req;

  logic [7:0] rda, rdb, nb_rda, nb_rdb, z_rda, z_rdb;
  logic       bsy, dn, nb_bsy, nb_dn, z_bsy, z_dn;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  banco_registros_param #(.WIDTH(8), .ADDR_W(3), .ZERO_REG(0), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .w_addr(w_addr), .w_data(w_data), .en_addr(en_addr),
    .r_addr_a(r_addr_a), .r_addr_b(r_addr_b), .r_data_a(rda), .r_data_b(rdb),
    .clr_req(clr_req), .busy(bsy), .clr_done(dn));

  banco_registros_param #(.WIDTH(8), .ADDR_W(3), .ZERO_REG(0), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .w_addr(w_addr), .w_data(w_data), .en_addr(en_addr),
    .r_addr_a(r_addr_a), .r_addr_b(r_addr_b), .r_data_a(nb_rda), .r_data_b(nb_rdb),
    .clr_req(clr_req), .busy(nb_bsy), .clr_done(nb_dn));

  banco_registros_param #(.WIDTH(8), .ADDR_W(3), .ZERO_REG(1), .BYPASS(1)) dut_z (
    .clk(clk), .rst(rst), .w_addr(w_addr), .w_data(w_data), .en_addr(en_addr),
    .r_addr_a(r_addr_a), .r_addr_b(r_addr_b), .r_data_a(z_rda), .r_data_b(z_rdb),
    .clr_req(clr_req), .busy(z_bsy), .clr_done(z_dn));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    w_addr = a; w_data = d; en_addr = 1'b1;
    tick();
    en_addr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en_addr = 1'b0; clr_req = 1'b0;
    w_addr = '0; w_data = '0; r_addr_a = '0; r_addr_b = '0;
    tick(); tick();
    n_tests++;
    if ({rda, rdb, bsy, dn} !== 18'h0) begin
      n_fail++; $display("FAIL reset_outputs: got %h %h %b %b, want 00 00 0 0", rda, rdb, bsy, dn);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write_read();
    wr(3'd3, 8'hA5);
    r_addr_a = 3'd3; r_addr_b = 3'd3;
    tick();
    n_tests++;
    if (rda !== 8'hA5 || rdb !== 8'hA5) begin
      n_fail++; $display("FAIL write_read_a5: got %h %h, want a5 a5", rda, rdb);
    end
    for (int i = 0; i < 8; i++) begin
      if (i == 3) continue;
      r_addr_a = 3'(i); r_addr_b = 3'(i);
      tick();
      n_tests++;
      if (rda !== 8'h00 || rdb !== 8'h00) begin
        n_fail++; $display("FAIL others_zero[%0d]: got %h %h, want 00 00", i, rda, rdb);
      end
    end
  endtask

  task automatic test_bypass();
    w_addr = 3'd2; w_data = 8'h3C; en_addr = 1'b1; r_addr_a = 3'd2;
    tick();
    en_addr = 1'b0;
    n_tests++;
    if (rda !== 8'h3C) begin
      n_fail++; $display("FAIL bypass_on: got %h, want 3c", rda);
    end
    n_tests++;
    if (nb_rda !== 8'h00) begin
      n_fail++; $display("FAIL bypass_off_old: got %h, want 00", nb_rda);
    end
    tick();
    n_tests++;
    if (nb_rda !== 8'h3C || rda !== 8'h3C) begin
      n_fail++; $display("FAIL bypass_off_new: got %h %h, want 3c 3c", nb_rda, rda);
    end
  endtask

  task automatic test_write_disable();
    w_addr = 3'd5; w_data = 8'hFF; en_addr = 1'b0; r_addr_a = 3'd5;
    tick(); tick();
    n_tests++;
    if (rda !== 8'h00) begin
      n_fail++; $display("FAIL en_low_dropped: got %h, want 00", rda);
    end
  endtask

  task automatic test_sweep();
    for (int i = 0; i < 8; i++) wr(3'(i), 8'h10 + 8'(i));
    for (int i = 0; i < 8; i++) begin
      r_addr_a = 3'(i); r_addr_b = 3'(7 - i);
      tick();
      n_tests++;
      if (rda !== 8'h10 + 8'(i) || rdb !== 8'h17 - 8'(i)) begin
        n_fail++; $display("FAIL sweep[%0d]: got %h %h, want %h %h", i, rda, rdb, 8'h10 + 8'(i), 8'h17 - 8'(i));
      end
    end
  endtask

  task automatic test_zero_reg();
    w_addr = 3'd0; w_data = 8'h77; en_addr = 1'b1; r_addr_b = 3'd0;
    tick();
    en_addr = 1'b0;
    n_tests++;
    if (z_rdb !== 8'h00 || rdb !== 8'h77) begin
      n_fail++; $display("FAIL zero_reg_bypass: got z=%h d=%h, want 00 77", z_rdb, rdb);
    end
    tick();
    n_tests++;
    if (z_rdb !== 8'h00 || rdb !== 8'h77) begin
      n_fail++; $display("FAIL zero_reg_later: got z=%h d=%h, want 00 77", z_rdb, rdb);
    end
  endtask

  task automatic run_clear(input string tag, input logic drop_writes);
    int cnt;
    int guard;
    cnt = 0; guard = 0;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    n_tests++;
    if (bsy !== 1'b1 || dn !== 1'b0) begin
      n_fail++; $display("FAIL %s_busy_start: got busy=%b done=%b, want 1 0", tag, bsy, dn);
    end
    while (bsy === 1'b1 && guard < 20) begin
      cnt++; guard++;
      if (drop_writes) begin
        w_addr = 3'(cnt); w_data = 8'hEE; en_addr = 1'b1;
      end
      tick();
    end
    en_addr = 1'b0;
    n_tests++;
    if (cnt != 8) begin
      n_fail++; $display("FAIL %s_busy_len: got %0d cycles, want 8", tag, cnt);
    end
    n_tests++;
    if (dn !== 1'b1 || bsy !== 1'b0) begin
      n_fail++; $display("FAIL %s_done_pulse: got done=%b busy=%b, want 1 0", tag, dn, bsy);
    end
    tick();
    n_tests++;
    if (dn !== 1'b0 || bsy !== 1'b0) begin
      n_fail++; $display("FAIL %s_done_width: got done=%b busy=%b, want 0 0", tag, dn, bsy);
    end
    for (int i = 0; i < 8; i++) begin
      r_addr_a = 3'(i); r_addr_b = 3'(i);
      tick();
      n_tests++;
      if (rda !== 8'h00 || rdb !== 8'h00) begin
        n_fail++; $display("FAIL %s_cleared[%0d]: got %h %h, want 00 00", tag, i, rda, rdb);
      end
    end
  endtask

  task automatic test_clear();
    for (int i = 0; i < 8; i++) wr(3'(i), 8'h80 + 8'(i));
    run_clear("clear", 1'b1);
  endtask

  task automatic test_reset_mid_clear();
    for (int i = 0; i < 8; i++) wr(3'(i), 8'hC0 + 8'(i));
    r_addr_a = 3'd7; r_addr_b = 3'd6;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    tick(); tick(); tick();
    n_tests++;
    if (bsy !== 1'b1 || rda !== 8'hC7) begin
      n_fail++; $display("FAIL mid_clear_pre: got busy=%b a=%h, want 1 c7", bsy, rda);
    end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({rda, rdb, bsy, dn} !== 18'h0) begin
      n_fail++; $display("FAIL mid_clear_reset: got %h %h %b %b, want 00 00 0 0", rda, rdb, bsy, dn);
    end
    tick();
    rst = 1'b0;
    tick();
    wr(3'd4, 8'h5A);
    run_clear("reclear", 1'b0);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_write_disable();
    test_sweep();
    test_zero_reg();
    test_clear();
    test_reset_mid_clear();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/banco_registros_param.md
Name: banco_registros_param

Overview:
- Parametrised register bank with integrated write-address decoder, 1 write port, 2 registered read ports.
- Adds read-during-write bypass, an optional hardwired-zero register 0, and a sequential bulk-clear engine with busy/done handshake.
- Sits in the datapath as the general-purpose register file; it replaces fixed 8-entry decode and storage.

Parameters:
- WIDTH, 8, data width of each register in bits.
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W registers (derived localparam, not overridable).
- ZERO_REG, 0, 1 = register 0 always reads 0 and ignores writes and clears.
- BYPASS, 1, 1 = a read of the address being written in the same cycle returns w_data.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous reset, active-high
- w_addr  input  ADDR_W  write address
- w_data  input  WIDTH  write data
- en_addr  input  1  write enable; decoder output is all-zero when low
- r_addr_a  input  ADDR_W  read address, port A
- r_addr_b  input  ADDR_W  read address, port B
- r_data_a  output  WIDTH  registered read data, port A
- r_data_b  output  WIDTH  registered read data, port B
- clr_req  input  1  bulk-clear request, sampled in IDLE only
- busy  output  1  high while the clear sweep runs
- clr_done  output  1  one-cycle pulse when the clear completes

Behaviour:
- Interface: single clock domain, clk; rst is asynchronous and active-high.
- Reset: all DEPTH registers 0, r_data_a/b 0, busy 0, clr_done 0, FSM in IDLE, clear pointer 0. Reset asserted mid-clear aborts the sweep with the same result.
- Write decode:
  - Internal one-hot of DEPTH bits, bit w_addr set only when en_addr=1 and busy=0.
  - The selected register loads w_data at the rising edge. No other register changes.
  - en_addr=1 while busy=1 is ignored; the write is dropped, not queued.
- Read timing:
  - Each port samples its address at the edge and presents data after 1 cycle.
  - Without bypass, the port returns the pre-edge contents.
  - Ports are independent. Both ports may read the same address.
- Bypass (BYPASS=1):
  - Condition: the write is effective and w_addr == r_addr_x.
  - Response: r_data_x <= w_data.
  - With BYPASS=0, the port returns the old value and the new value appears from the next read.
- ZERO_REG=1: address 0 always reads 0, including when bypassed; writes to address 0 have no effect.
- Clear FSM, states IDLE, CLEAR, DONE:
  - IDLE -> CLEAR when clr_req=1. Pointer is 0, busy=1 from the next cycle.
  - CLEAR: each cycle reg[ptr] <= 0 and ptr++. After clearing ptr = DEPTH-1, go to DONE; the pointer wraps to 0. Duration is DEPTH cycles with busy=1.
  - DONE: busy=0, clr_done=1 for exactly 1 cycle, then IDLE.
  - clr_req in CLEAR or DONE is ignored. A held clr_req restarts a sweep from IDLE.
- Simultaneous events:
  - clr_req and an effective write in the same IDLE cycle: the write commits at that edge and the sweep then erases it.
  - Reads during CLEAR are allowed and return current contents, whether already cleared or not. Bypass never applies during busy.
- busy and clr_done are registered FSM decodes and glitch-free.

Test Plan:
- Reset, then write 0xA5 to address 3 (en_addr=1), next cycle read A=3 -> r_data_a=0xA5 one cycle later; all other addresses read 0x00.
- en_addr=0 with w_addr=5, w_data=0xFF -> address 5 remains 0x00. Sweep w_addr 0..7 with data 0x10+i -> each reads back 0x10+i on both ports.
- Same-cycle write 0x3C to address 2 with r_addr_a=2: BYPASS=1 -> r_data_a=0x3C next cycle; BYPASS=0 -> old value 0x00, then 0x3C on the following read.
- ZERO_REG=1: write 0x77 to address 0 and read port B=0 -> 0x00, both bypassed and later.
- Fill all 8 registers, pulse clr_req -> busy high for exactly 8 cycles, then clr_done=1 for 1 cycle, busy=0. Writes issued during busy are dropped; afterwards all addresses read 0x00.
- Assert rst at cycle 4 of the clear sweep -> busy=0, clr_done=0, r_data 0 immediately without waiting for a clock edge. After release, a fresh clr_req performs a full 8-cycle sweep.
